// File: rtl/multi_cycle_core.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// multi_cycle_core : MIPS-subset multi-cycle CPU with one unified memory port
// Revision: 1.0
// ==========================================================================
module multi_cycle_core #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        halted,
  output logic [31:0] pc
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] tgt_q, tgt_d;
  logic        idle_q, idle_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext;
  logic        legal;

  assign opcode   = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  always_comb begin
    legal = 1'b0;
    if (opcode == OP_RTYPE) begin
      legal = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    end else begin
      legal = opcode inside {OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW};
    end
  end

  function automatic logic [31:0] alu_r(input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
    case (fn)
      FN_ADD:  return x + y;
      FN_SUB:  return x - y;
      FN_AND:  return x & y;
      FN_OR:   return x | y;
      FN_SLT:  return {31'd0, ($signed(x) < $signed(y))};
      default: return 32'd0;
    endcase
  endfunction

  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    tgt_d     = tgt_q;
    idle_d    = 1'b0;
    rf_d      = rf_q;
    wr_en     = 1'b0;
    wr_addr   = 5'd0;
    wr_data   = 32'd0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    mem_wdata = b_q;
    halted    = 1'b0;

    case (state_q)
      FETCH: begin
        // idle_q holds off the first request for one cycle after reset
        if (!idle_q) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_d    = mem_rdata;
            pc_d    = pc_q + 32'd4;
            state_d = DECODE;
          end
        end
      end
      DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        tgt_d = pc_q + {imm_sext[29:0], 2'b00};
        if (opcode == OP_J) begin
          pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
          state_d = FETCH;
        end else if (!legal) begin
          state_d = ILLEGAL_HALT ? HALT : FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            alu_d   = alu_r(funct, a_q, b_q);
            state_d = WB;
          end
          OP_ADDI: begin
            alu_d   = a_q + imm_sext;
            state_d = WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = a_q + imm_sext;
            state_d = MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = tgt_q;
            state_d = FETCH;
          end
          OP_BNE: begin
            if (a_q != b_q) pc_d = tgt_q;
            state_d = FETCH;
          end
          default: state_d = FETCH;
        endcase
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_addr = alu_q;
        mem_we   = (opcode == OP_SW);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            state_d = FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = WB;
          end
        end
      end
      WB: begin
        case (opcode)
          OP_RTYPE: begin wr_en = 1'b1; wr_addr = rd; wr_data = alu_q; end
          OP_ADDI:  begin wr_en = 1'b1; wr_addr = rt; wr_data = alu_q; end
          OP_LW:    begin wr_en = 1'b1; wr_addr = rt; wr_data = mdr_q; end
          default:  wr_en = 1'b0;
        endcase
        if (wr_en && (wr_addr != 5'd0)) rf_d[wr_addr] = wr_data;
        state_d = FETCH;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      tgt_q   <= '0;
      idle_q  <= 1'b1;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      tgt_q   <= tgt_d;
      idle_q  <= idle_d;
      rf_q    <= rf_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_multi_cycle_core.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_multi_cycle_core : scoreboard bench for multi_cycle_core
// Revision: 1.0
// ==========================================================================
module tb_multi_cycle_core;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam logic [5:0]  ADDI = 6'h08, LW = 6'h23, SW = 6'h2B, BEQ = 6'h04, BNE = 6'h05;
  localparam logic [5:0]  F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        j_req, j_we, j_ready, j_halted;
  logic [31:0] j_addr, j_wdata, j_rdata, j_pc;

  always #5 clk = ~clk;

  multi_cycle_core #(.RESET_PC(RST_PC), .ILLEGAL_HALT(1'b1)) u_dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .halted(halted), .pc(pc)
  );

  multi_cycle_core #(.RESET_PC(32'h1000_0000), .ILLEGAL_HALT(1'b1)) u_jump (
    .clk(clk), .reset(reset), .mem_req(j_req), .mem_we(j_we), .mem_addr(j_addr),
    .mem_wdata(j_wdata), .mem_rdata(j_rdata), .mem_ready(j_ready), .halted(j_halted), .pc(j_pc)
  );

  // second core only ever sees: j 0x40 at its reset PC, a self-loop elsewhere
  assign j_rdata = (j_addr == 32'h1000_0000) ? {6'h02, 26'h40} : 32'h1000_FFFF;
  assign j_ready = j_req;

  logic [31:0] mem [0:255];
  int fetch_wait = 0;
  int data_wait  = 0;
  int wcnt = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] wp;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q [$];
  wr_t mon_e;
  logic [31:0] fa_q [$];
  int          fc_q [$];

  logic        pend = 1'b0;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;

  assign mem_rdata = mem[mem_addr[9:2]];
  assign mem_ready = mem_req && (wcnt >= ((mem_addr < 32'h100) ? data_wait : fetch_wait));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || !mem_req || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // bus monitor: hold-stability, fetch trace, write scoreboard
  always @(negedge clk) begin
    if (reset || !mem_req) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        checks++;
        if (mem_addr !== s_addr || mem_we !== s_we || (mem_we && mem_wdata !== s_wdata)) begin
          errors++;
          $display("FAIL bus_stable: addr=%h we=%b wdata=%h, held values addr=%h we=%b wdata=%h",
                   mem_addr, mem_we, mem_wdata, s_addr, s_we, s_wdata);
        end
      end else if (!mem_we && mem_addr >= 32'h100) begin
        fa_q.push_back(mem_addr);
        fc_q.push_back(cyc);
      end
      if (mem_ready) begin
        pend = 1'b0;
        if (mem_we) begin
          mem[mem_addr[9:2]] = mem_wdata;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%h data=%h, none expected", mem_addr, mem_wdata);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.a !== mem_addr || mon_e.d !== mem_wdata) begin
              errors++;
              $display("FAIL store: addr=%h data=%h, expected addr=%h data=%h",
                       mem_addr, mem_wdata, mon_e.a, mon_e.d);
            end
          end
        end
      end else begin
        pend    = 1'b1;
        s_addr  = mem_addr;
        s_we    = mem_we;
        s_wdata = mem_wdata;
      end
    end
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic int first_fetch(input logic [31:0] a);
    for (int i = 0; i < fa_q.size(); i++) if (fa_q[i] == a) return fc_q[i];
    return -1;
  endfunction

  task automatic emit(input logic [31:0] w);
    mem[wp[9:2]] = w;
    wp = wp + 32'd4;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back('{a: a, d: d});
  endtask

  // leaves reset high with at least one edge sampled, memory cleared
  task automatic apply_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    exp_q.delete();
    fa_q.delete();
    fc_q.delete();
    fetch_wait = 0;
    data_wait  = 0;
    wp = RST_PC;
  endtask

  task automatic release_reset();
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic wait_halt(input string name, input int budget);
    for (int i = 0; i < budget && halted !== 1'b1; i++) @(negedge clk);
    checks++;
    if (halted !== 1'b1) begin
      errors++;
      $display("FAIL %s_halt: halted=%b after %0d cycles, expected 1", name, halted, budget);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    emit(HALT_W);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL reset_bus: req=%b we=%b, expected 0 0", mem_req, mem_we);
    end
    checks++;
    if (halted !== 1'b0 || pc !== RST_PC) begin
      errors++; $display("FAIL reset_state: halted=%b pc=%h, expected 0 %h", halted, pc, RST_PC);
    end
    release_reset();
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_gap: req=%b, expected 0", mem_req);
    end
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== RST_PC || halted !== 1'b0) begin
      errors++;
      $display("FAIL first_fetch: req=%b we=%b addr=%h halted=%b, expected 1 0 %h 0",
               mem_req, mem_we, mem_addr, halted, RST_PC);
    end
  endtask

  task automatic test_alu();
    apply_reset();
    emit(itype(ADDI, 5'd0, 5'd1, 16'd5));
    emit(itype(ADDI, 5'd0, 5'd2, 16'hFFFD));
    emit(rtype(5'd1, 5'd2, 5'd3, F_ADD));
    emit(rtype(5'd2, 5'd1, 5'd4, F_SLT));
    emit(rtype(5'd1, 5'd2, 5'd6, F_SUB));
    emit(rtype(5'd1, 5'd2, 5'd7, F_AND));
    emit(rtype(5'd1, 5'd2, 5'd8, F_OR));
    emit(rtype(5'd1, 5'd2, 5'd9, F_SLT));
    emit(itype(ADDI, 5'd0, 5'd0, 16'd7));
    emit(itype(SW, 5'd0, 5'd3, 16'h10)); push_exp(32'h10, 32'd2);
    emit(itype(SW, 5'd0, 5'd4, 16'h14)); push_exp(32'h14, 32'd1);
    emit(itype(SW, 5'd0, 5'd6, 16'h18)); push_exp(32'h18, 32'd8);
    emit(itype(SW, 5'd0, 5'd7, 16'h1C)); push_exp(32'h1C, 32'd5);
    emit(itype(SW, 5'd0, 5'd8, 16'h20)); push_exp(32'h20, 32'hFFFF_FFFD);
    emit(itype(SW, 5'd0, 5'd9, 16'h24)); push_exp(32'h24, 32'd0);
    emit(itype(SW, 5'd0, 5'd0, 16'h28)); push_exp(32'h28, 32'd0);
    emit(32'h0000_0000);
    release_reset();
    wait_halt("alu", 300);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL alu_stores: %0d stores missing, expected 0", exp_q.size());
    end
    checks++;
    if (first_fetch(32'h10C) - first_fetch(32'h108) != 4) begin
      errors++; $display("FAIL add_cycles: %0d, expected 4", first_fetch(32'h10C) - first_fetch(32'h108));
    end
    checks++;
    if (first_fetch(32'h104) - first_fetch(32'h100) != 4) begin
      errors++; $display("FAIL addi_cycles: %0d, expected 4", first_fetch(32'h104) - first_fetch(32'h100));
    end
    checks++;
    if (first_fetch(32'h128) - first_fetch(32'h124) != 4) begin
      errors++; $display("FAIL sw_cycles: %0d, expected 4", first_fetch(32'h128) - first_fetch(32'h124));
    end
    checks++;
    if (pc !== 32'h144) begin
      errors++; $display("FAIL alu_halt_pc: pc=%h, expected 00000144", pc);
    end
  endtask

  task automatic test_mem_wait();
    apply_reset();
    data_wait = 2;
    mem[2] = 32'hDEAD_BEEF;
    emit(itype(ADDI, 5'd0, 5'd3, 16'd2));
    emit(itype(SW, 5'd0, 5'd3, 16'd8));  push_exp(32'h8, 32'd2);
    emit(itype(LW, 5'd0, 5'd5, 16'd8));
    emit(itype(SW, 5'd0, 5'd5, 16'h30)); push_exp(32'h30, 32'd2);
    emit(HALT_W);
    release_reset();
    wait_halt("memwait", 200);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL memwait_stores: %0d stores missing, expected 0", exp_q.size());
    end
    checks++;
    if (first_fetch(32'h108) - first_fetch(32'h104) != 6) begin
      errors++; $display("FAIL sw_wait_cycles: %0d, expected 6", first_fetch(32'h108) - first_fetch(32'h104));
    end
    checks++;
    if (first_fetch(32'h10C) - first_fetch(32'h108) != 7) begin
      errors++; $display("FAIL lw_wait_cycles: %0d, expected 7", first_fetch(32'h10C) - first_fetch(32'h108));
    end
  endtask

  task automatic test_branch();
    int i0;
    int n;
    bit ok;
    apply_reset();
    emit(itype(ADDI, 5'd0, 5'd1, 16'd1));
    emit(itype(BNE, 5'd1, 5'd1, 16'd5));
    emit(itype(BEQ, 5'd1, 5'd0, 16'd5));
    emit(itype(BNE, 5'd1, 5'd0, 16'd1));
    emit(itype(SW, 5'd0, 5'd1, 16'h44));
    emit(itype(SW, 5'd0, 5'd1, 16'h40)); push_exp(32'h40, 32'd1);
    emit(itype(BEQ, 5'd1, 5'd1, 16'hFFFF));
    release_reset();
    repeat (60) @(negedge clk);
    checks++;
    if (first_fetch(32'h108) - first_fetch(32'h104) != 3) begin
      errors++; $display("FAIL bne_fall_cycles: %0d, expected 3", first_fetch(32'h108) - first_fetch(32'h104));
    end
    checks++;
    if (first_fetch(32'h10C) - first_fetch(32'h108) != 3) begin
      errors++; $display("FAIL beq_fall_cycles: %0d, expected 3", first_fetch(32'h10C) - first_fetch(32'h108));
    end
    checks++;
    if (first_fetch(32'h110) != -1 || first_fetch(32'h114) - first_fetch(32'h10C) != 3) begin
      errors++;
      $display("FAIL bne_taken: skipped-slot fetch at %0d, gap %0d, expected none and 3",
               first_fetch(32'h110), first_fetch(32'h114) - first_fetch(32'h10C));
    end
    i0 = -1;
    for (int i = 0; i < fa_q.size(); i++) if (i0 < 0 && fa_q[i] == 32'h118) i0 = i;
    ok = (i0 > 0);
    n = 0;
    if (ok) begin
      for (int i = i0 + 1; i < fa_q.size(); i++) begin
        if (fa_q[i] != 32'h118 || fc_q[i] - fc_q[i-1] != 3) ok = 1'b0;
        n++;
      end
    end
    checks++;
    if (!ok || n < 5) begin
      errors++; $display("FAIL beq_loop: ok=%0d iterations=%0d, expected 1 and >=5", ok, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL branch_stores: %0d stores missing, expected 0", exp_q.size());
    end
  endtask

  task automatic test_jump();
    apply_reset();
    emit(HALT_W);
    release_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (j_req !== 1'b1 || j_we !== 1'b0 || j_addr !== 32'h1000_0000) begin
      errors++; $display("FAIL j_fetch: req=%b we=%b addr=%h, expected 1 0 10000000", j_req, j_we, j_addr);
    end
    @(negedge clk);
    checks++;
    if (j_req !== 1'b0) begin
      errors++; $display("FAIL j_decode_req: req=%b, expected 0", j_req);
    end
    @(negedge clk);
    checks++;
    if (j_req !== 1'b1 || j_addr !== 32'h1000_0100 || j_pc !== 32'h1000_0100 || j_halted !== 1'b0) begin
      errors++;
      $display("FAIL j_target: req=%b addr=%h pc=%h halted=%b, expected 1 10000100 10000100 0",
               j_req, j_addr, j_pc, j_halted);
    end
  endtask

  task automatic test_illegal();
    bit quiet;
    logic [31:0] pc_hold;
    apply_reset();
    emit(itype(ADDI, 5'd0, 5'd1, 16'd9));
    emit(itype(SW, 5'd0, 5'd1, 16'h50)); push_exp(32'h50, 32'd9);
    emit(HALT_W);
    emit(itype(SW, 5'd0, 5'd1, 16'h54));
    release_reset();
    wait_halt("illegal", 100);
    checks++;
    if (pc !== 32'h10C) begin
      errors++; $display("FAIL illegal_pc: pc=%h, expected 0000010C", pc);
    end
    pc_hold = pc;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (mem_req !== 1'b0 || halted !== 1'b1 || pc !== pc_hold) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++; $display("FAIL halt_frozen: quiet=%0d, expected 1", quiet);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL illegal_stores: %0d stores missing, expected 0", exp_q.size());
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_reset: req=%b we=%b halted=%b, expected 0 0 0", mem_req, mem_we, halted);
    end
    release_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RST_PC) begin
      errors++; $display("FAIL halt_refetch: req=%b addr=%h, expected 1 %h", mem_req, mem_addr, RST_PC);
    end
  endtask

  task automatic test_reset_mid_lw();
    int k;
    apply_reset();
    data_wait = 1000;
    mem[2] = 32'h0000_1234;
    emit(itype(ADDI, 5'd0, 5'd5, 16'd3));
    emit(itype(LW, 5'd0, 5'd5, 16'd8));
    emit(itype(SW, 5'd0, 5'd5, 16'h60));
    emit(HALT_W);
    release_reset();
    k = 0;
    while (k < 60 && !(mem_req === 1'b1 && mem_addr === 32'h8)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 60) begin
      errors++; $display("FAIL lw_reach_mem: no data request within 60 cycles, expected one");
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    data_wait = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL abandon_bus: req=%b we=%b, expected 0 0", mem_req, mem_we);
    end
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[2] = 32'h0000_1234;
    wp = RST_PC;
    emit(itype(SW, 5'd0, 5'd5, 16'h60)); push_exp(32'h60, 32'd0);
    emit(HALT_W);
    release_reset();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== RST_PC || mem_we !== 1'b0) begin
      errors++; $display("FAIL abandon_refetch: req=%b addr=%h we=%b, expected 1 %h 0", mem_req, mem_addr, mem_we, RST_PC);
    end
    wait_halt("abandon", 100);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL abandon_stores: %0d stores missing, expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_wait();
    test_branch();
    test_jump();
    test_illegal();
    test_reset_mid_lw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/multi_cycle_core.md
MULTI_CYCLE_CORE -- requirements
Module: multi_cycle_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter ILLEGAL_HALT, default 1: 1 = unsupported opcode/funct enters HALT; 0 = treated as NOP.
REQ-003 clk  input  1  core clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_req  output  1  memory transaction request.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 mem_addr  output  32  byte address, word aligned.
REQ-008 mem_wdata  output  32  store data; valid while mem_req=1 and mem_we=1.
REQ-009 mem_rdata  input  32  read data; sampled in the cycle mem_ready=1.
REQ-010 mem_ready  input  1  transaction completes in any cycle with mem_req=1 and mem_ready=1.
REQ-011 halted  output  1  core is in HALT.
REQ-012 pc  output  32  current PC (debug).

Function
REQ-013 Unified instruction/data port: one FSM, states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-014 Supported: R-type add, sub, and, or, slt (op 0, funct 0x20/0x22/0x24/0x25/0x2A); addi 0x08; lw 0x23; sw 0x2B; beq 0x04; bne 0x05; j 0x02.
REQ-015 FETCH: mem_req=1, mem_we=0, mem_addr=pc; stay until mem_ready; on ready IR<=mem_rdata, pc<=pc+4, ->DECODE.
REQ-016 DECODE: A<=R[rs], B<=R[rt], TGT<=pc+(sext(imm)<<2) (pc already +4); j: pc<={pc[31:28],IR[25:0],2'b00}, ->FETCH; illegal with ILLEGAL_HALT=1: ->HALT; illegal with ILLEGAL_HALT=0: ->FETCH; else ->EXEC.
REQ-017 EXEC: ALUOUT<=A op (B or sext(imm)); beq taken if A==B, bne taken if A!=B; taken: pc<=TGT; branches ->FETCH; R-type/addi ->WB; lw/sw: ALUOUT<=A+sext(imm), ->MEM.
REQ-018 MEM: mem_req=1, mem_addr=ALUOUT, mem_we=1 for sw with mem_wdata=B; stay until mem_ready; sw ->FETCH; lw: MDR<=mem_rdata, ->WB.
REQ-019 WB: R-type writes ALUOUT to rd; addi writes ALUOUT to rt; lw writes MDR to rt; ->FETCH.
REQ-020 Writes to register 0 are discarded; R[0] always reads 0.
REQ-021 Arithmetic 32-bit modulo 2^32, no overflow exception; slt is signed compare, result 0 or 1.
REQ-022 Low 2 bits of mem_addr are passed unmodified; no alignment check.
REQ-023 mem_addr, mem_we, mem_wdata are stable from mem_req rise until the cycle mem_ready=1; mem_req drops the cycle after completion unless next state also requests.
REQ-024 mem_ready with mem_req=0 is ignored.
REQ-025 Zero-wait cycle counts: j 2, beq/bne 3, R-type/addi/sw 4, lw 5; each wait cycle adds one.
REQ-026 HALT: mem_req=0, halted=1, pc frozen; exit only by reset.
REQ-027 No stall/timeout on mem_ready: core waits indefinitely.

Reset
REQ-028 In a cycle with reset=1: next state FETCH, pc<=RESET_PC, R[1..31], IR, A, B, ALUOUT, MDR, TGT <=0, halted<=0.
REQ-029 mem_req=0, mem_we=0 in the cycle after reset is sampled high, regardless of prior state.
REQ-030 Reset mid-transaction abandons it; no register or pc update from that transaction.
REQ-031 First fetch at RESET_PC issues the cycle after reset deasserts.

Verification
REQ-032 Reset with RESET_PC=32'h100, zero-wait memory -> first mem_req with mem_addr=32'h100, mem_we=0; halted=0.
REQ-033 addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1 -> R3=2, R4=1; add completes in 4 cycles.
REQ-034 sw $3,8($0) then lw $5,8($0), memory with 2 wait states -> write at addr 8 data 2, signals stable during waits; R5=2; lw 7 cycles.
REQ-035 beq $1,$1,-1 loop and bne $1,$1 fallthrough -> pc returns to branch address each 3 cycles; bne continues at pc+4; j 0x40 at pc 0x1000_0000 -> pc=0x1000_0100.
REQ-036 Opcode 0x3F with ILLEGAL_HALT=1 -> halted=1, mem_req=0 thereafter; reset -> fetch resumes at RESET_PC.
REQ-037 reset asserted during lw MEM wait -> mem_req=0 next cycle, destination register unchanged, fetch restarts at RESET_PC.
